// File: rtl/dna_pkg.sv
// Shared nucleotide types and ASCII decode helper for the DNA packing stages.
package dna_pkg;

    typedef enum logic [1:0] {BASE_A, BASE_C, BASE_G, BASE_T} dna_base_t;
    typedef enum logic [1:0] {ST_IDLE, ST_PACK, ST_EMIT} pack_state_t;

    localparam logic [7:0] ASCII_A_UC = 8'h41;
    localparam logic [7:0] ASCII_A_LC = 8'h61;
    localparam logic [7:0] ASCII_C_UC = 8'h43;
    localparam logic [7:0] ASCII_C_LC = 8'h63;
    localparam logic [7:0] ASCII_G_UC = 8'h47;
    localparam logic [7:0] ASCII_G_LC = 8'h67;
    localparam logic [7:0] ASCII_T_UC = 8'h54;
    localparam logic [7:0] ASCII_T_LC = 8'h74;

    function automatic void ascii_to_base(input logic [7:0] c, output dna_base_t b, output logic ok);
        b  = BASE_A;
        ok = 1'b1;
        case (c)
            ASCII_A_UC, ASCII_A_LC: b = BASE_A;
            ASCII_C_UC, ASCII_C_LC: b = BASE_C;
            ASCII_G_UC, ASCII_G_LC: b = BASE_G;
            ASCII_T_UC, ASCII_T_LC: b = BASE_T;
            default:                ok = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dna_base_encoder.sv
// Combinational ASCII nucleotide to 2-bit code; ok is low for anything but A/C/G/T.
module dna_base_encoder
    import dna_pkg::*;
(
    input  logic [7:0] ch,
    output logic       ok,
    output dna_base_t  base
);

    always_comb begin
        base = BASE_A;
        ok   = 1'b0;
        ascii_to_base(ch, base, ok);
    end

endmodule

// File: rtl/dna_base_packer.sv
// Packs 2-bit nucleotide codes LSB-first into FIFO words and shadows the FIFO
// occupancy, since the FIFO itself exposes no full/empty flags.
module dna_base_packer
    import dna_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  en,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    input  logic [7:0]                            s_char,
    input  logic                                  s_last,
    input  logic [7:0]                            fifo_depth,
    input  logic                                  fifo_rd,
    output logic                                  fifo_wr,
    output logic [DATA_WIDTH-1:0]                 fifo_w_data,
    output logic [$clog2(DATA_WIDTH/2+1)-1:0]     tail_bases,
    output logic [7:0]                            level,
    output logic                                  full,
    output logic [15:0]                           invalid_cnt,
    output logic                                  busy
);

    localparam int BPW = DATA_WIDTH / 2;
    localparam int TW  = $clog2(BPW + 1);

    pack_state_t           state_reg, state_next;
    logic [DATA_WIDTH-1:0] pack_reg, pack_next;
    logic [DATA_WIDTH-1:0] pend_word_reg, pend_word_next;
    logic [DATA_WIDTH-1:0] merged_word;
    logic [TW-1:0]         idx_reg, idx_next, idx_inc;
    logic [TW-1:0]         tail_reg, tail_next;
    logic [7:0]            level_reg, level_next;
    logic [15:0]           inv_reg, inv_next;
    logic                  pend, accept, pop, complete, base_ok;
    dna_base_t             base;

    dna_base_encoder u_encoder (
        .ch   (s_char),
        .ok   (base_ok),
        .base (base)
    );

    assign pend    = (state_reg == ST_EMIT);
    assign fifo_wr = en & pend & (level_reg < fifo_depth);
    // A pending word only blocks input when it cannot drain this cycle.
    assign s_ready = en & (~pend | fifo_wr);
    assign accept  = s_valid & s_ready;
    assign pop     = en & fifo_rd & (level_reg != 8'd0);
    assign idx_inc = idx_reg + TW'(1);

    // Slot idx_reg takes the incoming base; slots above it are still zero.
    generate
        for (genvar gi = 0; gi < BPW; gi++) begin : g_merge
            assign merged_word[2*gi+1:2*gi] = (idx_reg == TW'(gi)) ? base : pack_reg[2*gi+1:2*gi];
        end
    endgenerate

    always_comb begin
        pack_next      = pack_reg;
        pend_word_next = pend_word_reg;
        idx_next       = idx_reg;
        tail_next      = tail_reg;
        inv_next       = inv_reg;
        complete       = 1'b0;
        level_next     = level_reg + {7'd0, fifo_wr} - {7'd0, pop};

        if (accept) begin
            if (base_ok) begin
                if ((idx_inc == TW'(BPW)) || s_last) begin
                    complete       = 1'b1;
                    pend_word_next = merged_word;
                    tail_next      = idx_inc;
                    pack_next      = '0;
                    idx_next       = '0;
                end else begin
                    pack_next = merged_word;
                    idx_next  = idx_inc;
                end
            end else begin
                if (inv_reg != 16'hFFFF) begin
                    inv_next = inv_reg + 16'd1;
                end
                if (s_last && (idx_reg != '0)) begin
                    complete       = 1'b1;
                    pend_word_next = pack_reg;
                    tail_next      = idx_reg;
                    pack_next      = '0;
                    idx_next       = '0;
                end
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_PACK: begin
                if (complete)
                    state_next = ST_EMIT;
                else
                    state_next = (idx_next != '0) ? ST_PACK : ST_IDLE;
            end
            ST_EMIT: begin
                if (complete)
                    state_next = ST_EMIT;
                else if (fifo_wr)
                    state_next = (idx_next != '0) ? ST_PACK : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            pack_reg      <= '0;
            pend_word_reg <= '0;
            idx_reg       <= '0;
            tail_reg      <= '0;
            level_reg     <= '0;
            inv_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            pack_reg      <= pack_next;
            pend_word_reg <= pend_word_next;
            idx_reg       <= idx_next;
            tail_reg      <= tail_next;
            level_reg     <= level_next;
            inv_reg       <= inv_next;
        end
    end

    assign fifo_w_data = pend_word_reg;
    assign tail_bases  = tail_reg;
    assign level       = level_reg;
    assign full        = (level_reg >= fifo_depth);
    assign invalid_cnt = inv_reg;
    assign busy        = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_dna_base_packer.sv
// Directed bench for dna_base_packer at DATA_WIDTH=8 with hand-computed packed words.
module tb_dna_base_packer;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset, en, s_valid, s_last, fifo_rd;
    logic [7:0]    s_char, fifo_depth;
    logic          s_ready, fifo_wr, full, busy;
    logic [DW-1:0] fifo_w_data;
    logic [2:0]    tail_bases;
    logic [7:0]    level;
    logic [15:0]   invalid_cnt;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int wr_count = 0;
    int wr_cyc = 0;
    int acc_cyc = 0;
    logic [DW-1:0] last_wdata = '0;

    dna_base_packer #(.DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_char      (s_char),
        .s_last      (s_last),
        .fifo_depth  (fifo_depth),
        .fifo_rd     (fifo_rd),
        .fifo_wr     (fifo_wr),
        .fifo_w_data (fifo_w_data),
        .tail_bases  (tail_bases),
        .level       (level),
        .full        (full),
        .invalid_cnt (invalid_cnt),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs change just after posedge, so fifo_wr at negedge means a write on the next edge.
    always @(negedge clk) begin
        if (fifo_wr) begin
            wr_count   = wr_count + 1;
            last_wdata = fifo_w_data;
            wr_cyc     = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] c, input logic last);
        int waited = 0;
        s_valid = 1'b1;
        s_char  = c;
        s_last  = last;
        while (1) begin
            @(negedge clk);
            if (s_ready) break;
            waited++;
            if (waited > 50) begin
                check("accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_str(input string s, input logic last_on_end);
        for (int i = 0; i < s.len(); i++)
            send(s[i], last_on_end && (i == s.len() - 1));
    endtask

    task automatic pop_n(input int n);
        fifo_rd = 1'b1;
        tick(n);
        fifo_rd = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_char = 8'h00;
        fifo_rd = 1'b0; fifo_depth = 8'd4;
        tick(3);
        check("rst_s_ready", s_ready, 0);
        check("rst_fifo_wr", fifo_wr, 0);
        check("rst_w_data", fifo_w_data, 0);
        check("rst_level", level, 0);
        check("rst_busy", busy, 0);
        check("rst_invalid", invalid_cnt, 0);
        check("rst_tail", tail_bases, 0);
        reset = 1'b0;
        en    = 1'b1;
        tick(1);

        // ACGT -> E4, one cycle after T is accepted
        send_str("ACGT", 1'b0);
        check("acgt_busy_pend", busy, 1);
        tick(1);
        check("acgt_wr_count", wr_count, 1);
        check("acgt_w_data", last_wdata, 32'hE4);
        check("acgt_latency", wr_cyc - acc_cyc, 1);
        check("acgt_level", level, 1);
        check("acgt_tail", tail_bases, 4);
        check("acgt_idle", busy, 0);

        // GA with last on A -> 02, partial word of two bases
        send_str("GA", 1'b1);
        tick(1);
        check("ga_wr_count", wr_count, 2);
        check("ga_w_data", last_wdata, 32'h02);
        check("ga_tail", tail_bases, 2);
        check("ga_idle", busy, 0);
        check("ga_level", level, 2);

        // drain, including one pop at level 0 which must be ignored
        pop_n(3);
        check("drain_level0", level, 0);

        // invalid characters dropped, then completion
        send_str("AxCN", 1'b0);
        check("axcn_invalid", invalid_cnt, 2);
        check("axcn_no_word", wr_count, 2);
        check("axcn_busy", busy, 1);
        send_str("GT", 1'b0);
        tick(1);
        check("axcngt_w_data", last_wdata, 32'hE4);
        check("axcngt_wr_count", wr_count, 3);

        // invalid character carrying s_last still flushes the partial word
        send("g", 1'b0);
        send("Z", 1'b1);
        tick(1);
        check("flush_w_data", last_wdata, 32'h02);
        check("flush_tail", tail_bases, 1);
        check("flush_invalid", invalid_cnt, 3);
        check("flush_level", level, 2);
        pop_n(2);

        // asynchronous reset mid-word discards the partial
        send_str("AC", 1'b0);
        check("mid_busy", busy, 1);
        reset = 1'b1;
        #2;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_level", level, 0);
        check("mid_rst_invalid", invalid_cnt, 0);
        tick(2);
        reset = 1'b0;
        tick(1);
        check("mid_rst_no_wr", wr_count, 4);
        send_str("tttt", 1'b0);
        tick(1);
        check("tttt_w_data", last_wdata, 32'hFF);
        check("tttt_wr_count", wr_count, 5);
        pop_n(1);
        check("tttt_drain", level, 0);

        // depth 2, no pops: third word stalls
        fifo_depth = 8'd2;
        send_str("ACGTACGTCCCC", 1'b0);
        tick(2);
        check("full_wr_count", wr_count, 7);
        check("full_flag", full, 1);
        check("full_level", level, 2);
        s_valid = 1'b1; s_char = "A";
        #1;
        check("full_s_ready", s_ready, 0);
        s_valid = 1'b0;
        pop_n(1);
        check("pop_level", level, 1);
        tick(1);
        check("refill_level", level, 2);
        check("refill_w_data", last_wdata, 32'h55);
        check("refill_wr_count", wr_count, 8);

        // en low freezes a pending word while fifo_rd pulses
        fifo_depth = 8'd4;
        send_str("ACGT", 1'b0);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fifo_rd = (i % 2 == 0);
            #1;
            check("en_low_s_ready", s_ready, 0);
            check("en_low_fifo_wr", fifo_wr, 0);
            tick(1);
        end
        fifo_rd = 1'b0;
        check("en_low_level", level, 2);
        check("en_low_wr_count", wr_count, 8);
        en = 1'b1;
        #1;
        check("en_back_fifo_wr", fifo_wr, 1);
        tick(1);
        check("en_back_wr_count", wr_count, 9);
        check("en_back_level", level, 3);
        check("en_back_w_data", last_wdata, 32'hE4);

        // depth 0 is permanently full
        fifo_depth = 8'd0;
        #1;
        check("depth0_full", full, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
